// File: rtl/finalprojsoc_spi_slave.sv
// Mode-0, MSB-first, 8-bit SPI responder with a two-cycle Avalon-style register port.
// Define FINALPROJSOC_SPI_SLAVE_IRQ_EN to enable the control register and the irq output.
module finalprojsoc_spi_slave #(
   parameter logic [7:0] FILL_BYTE = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spi_select,
   input  logic [2:0]  mem_addr,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [15:0] data_from_cpu,
   output logic [15:0] data_to_cpu,
   input  logic        SCLK,
   input  logic        MOSI,
   input  logic        SS_n,
   output logic        MISO,
   output logic        MISO_en,
   output logic        irq,
   output logic        dataavailable,
   output logic        readyfordata
);
   localparam int DATABITS = 8;

   logic [2:0]          sclk_sync;
   logic [1:0]          mosi_sync;
   logic [2:0]          ss_sync;
   logic                rd_strobe, wr_strobe;
   logic                selected;
   logic [2:0]          bitcnt;
   logic [DATABITS-2:0] rx_shift;
   logic [DATABITS-1:0] rx_holding;
   logic [DATABITS-1:0] tx_shift;
   logic [DATABITS-1:0] tx_holding;
   logic                primed;
   logic                roe, toe, tur, rrdy;
   logic [15:0]         status_word;
   logic [15:0]         control_word;

   logic sclk_rise, sclk_fall, ss_fall, ss_rise;
   logic p1_rd, p1_wr;
   logic rx_read, tx_write, stat_write, ctrl_write;
   logic shift_en, tx_load, byte_done;
   logic trdy, tmt;

   // Sync flops reset low so an SS_n held low across reset never looks like a fresh select.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_sync   <= '0;
         rd_strobe <= 1'b0;
         wr_strobe <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[1:0], SCLK};
         mosi_sync <= {mosi_sync[0], MOSI};
         ss_sync   <= {ss_sync[1:0], SS_n};
         rd_strobe <= p1_rd;
         wr_strobe <= p1_wr;
      end
   end

   assign sclk_rise  = sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall  = ~sclk_sync[1] & sclk_sync[2];
   assign ss_fall    = ~ss_sync[1] & ss_sync[2];
   assign ss_rise    = ss_sync[1] & ~ss_sync[2];

   assign p1_rd      = ~rd_strobe & spi_select & ~read_n;
   assign p1_wr      = ~wr_strobe & spi_select & ~write_n;
   assign rx_read    = rd_strobe & (mem_addr == 3'd0);
   assign tx_write   = wr_strobe & (mem_addr == 3'd1);
   assign stat_write = wr_strobe & (mem_addr == 3'd2);
   assign ctrl_write = wr_strobe & (mem_addr == 3'd3);

   assign shift_en   = selected & ~ss_rise;
   assign tx_load    = ss_fall | (shift_en & sclk_fall & (bitcnt == 3'd0));
   assign byte_done  = shift_en & sclk_rise & (bitcnt == 3'd7);

   assign trdy        = ~primed;
   assign tmt         = ~primed & ~selected;
   assign status_word = {6'd0, tur, roe | toe | tur, rrdy, trdy, tmt, toe, roe, 3'd0};

   // Clears are listed before sets so a same-cycle set event always wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         selected   <= 1'b0;
         bitcnt     <= 3'd0;
         rx_shift   <= '0;
         rx_holding <= '0;
         tx_shift   <= '0;
         tx_holding <= '0;
         primed     <= 1'b0;
         roe        <= 1'b0;
         toe        <= 1'b0;
         tur        <= 1'b0;
         rrdy       <= 1'b0;
      end else begin
         if (ss_fall) begin
            selected <= 1'b1;
            bitcnt   <= 3'd0;
         end else if (ss_rise) begin
            selected <= 1'b0;
            bitcnt   <= 3'd0;
         end else if (selected && sclk_rise) begin
            rx_shift <= {rx_shift[DATABITS-3:0], mosi_sync[1]};
            bitcnt   <= bitcnt + 3'd1;
         end

         if (tx_load) begin
            tx_shift <= primed ? tx_holding : FILL_BYTE;
         end else if (shift_en && sclk_fall) begin
            tx_shift <= {tx_shift[DATABITS-2:0], 1'b0};
         end

         if (stat_write) begin
            roe  <= 1'b0;
            toe  <= 1'b0;
            tur  <= 1'b0;
            rrdy <= 1'b0;
         end
         if (rx_read) begin
            rrdy <= 1'b0;
         end
         if (tx_load) begin
            primed <= 1'b0;
            if (!primed) begin
               tur <= 1'b1;
            end
         end
         if (byte_done) begin
            rx_holding <= {rx_shift, mosi_sync[1]};
            rrdy       <= 1'b1;
            if (rrdy && !rx_read) begin
               roe <= 1'b1;
            end
         end
         // A write is judged against the holding state before any same-cycle load.
         if (tx_write) begin
            if (primed) begin
               toe <= 1'b1;
            end else begin
               tx_holding <= data_from_cpu[DATABITS-1:0];
               primed     <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_to_cpu <= 16'd0;
      end else begin
         case (mem_addr)
            3'd0:    data_to_cpu <= {8'd0, rx_holding};
            3'd2:    data_to_cpu <= status_word;
            3'd3:    data_to_cpu <= control_word;
            default: data_to_cpu <= 16'd0;
         endcase
      end
   end

`ifdef FINALPROJSOC_SPI_SLAVE_IRQ_EN
   localparam logic [15:0] CTRL_MASK = 16'h03D8;
   logic [15:0] control;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         control <= 16'd0;
         irq     <= 1'b0;
      end else begin
         if (ctrl_write) begin
            control <= data_from_cpu & CTRL_MASK;
         end
         irq <= |(control & status_word);
      end
   end

   assign control_word = control;
`else
   logic unused_bits;
   assign unused_bits  = &{1'b0, ctrl_write, data_from_cpu[15:8]};
   assign control_word = 16'd0;
   assign irq          = 1'b0;
`endif

   assign MISO          = tx_shift[DATABITS-1];
   assign MISO_en       = selected;
   assign dataavailable = rrdy;
   assign readyfordata  = trdy;

endmodule

// File: tb/tb_finalprojsoc_spi_slave.sv
// Bench for finalprojsoc_spi_slave: a frame vector table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_finalprojsoc_spi_slave;
   logic        clk = 1'b0;
   logic        reset;
   logic        spi_select;
   logic [2:0]  mem_addr;
   logic        read_n;
   logic        write_n;
   logic [15:0] data_from_cpu;
   logic [15:0] data_to_cpu;
   logic        SCLK;
   logic        MOSI;
   logic        SS_n;
   logic        MISO;
   logic        MISO_en;
   logic        irq;
   logic        dataavailable;
   logic        readyfordata;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic        queue_tx;
      logic [7:0]  tx_byte;
      logic [7:0]  mosi_byte;
      logic [7:0]  exp_miso;
      logic [7:0]  exp_rx;
      logic [15:0] exp_status;
   } frame_vec_t;

   frame_vec_t vecs [5];

   always #10 clk = ~clk;

   finalprojsoc_spi_slave dut (
      .clk           (clk),
      .reset         (reset),
      .spi_select    (spi_select),
      .mem_addr      (mem_addr),
      .read_n        (read_n),
      .write_n       (write_n),
      .data_from_cpu (data_from_cpu),
      .data_to_cpu   (data_to_cpu),
      .SCLK          (SCLK),
      .MOSI          (MOSI),
      .SS_n          (SS_n),
      .MISO          (MISO),
      .MISO_en       (MISO_en),
      .irq           (irq),
      .dataavailable (dataavailable),
      .readyfordata  (readyfordata)
   );

   task automatic waitClocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
      end
   endtask

   task automatic cpuWrite(input logic [2:0] addr, input logic [15:0] data);
      @(negedge clk);
      spi_select    = 1'b1;
      mem_addr      = addr;
      data_from_cpu = data;
      write_n       = 1'b0;
      waitClocks(2);
      spi_select    = 1'b0;
      write_n       = 1'b1;
      waitClocks(1);
   endtask

   task automatic cpuRead(input logic [2:0] addr, output logic [15:0] data);
      @(negedge clk);
      spi_select = 1'b1;
      mem_addr   = addr;
      read_n     = 1'b0;
      waitClocks(2);
      data       = data_to_cpu;
      spi_select = 1'b0;
      read_n     = 1'b1;
      waitClocks(1);
   endtask

   task automatic selectSlave();
      @(negedge clk);
      SS_n = 1'b0;
      waitClocks(10);
   endtask

   task automatic deselectSlave();
      waitClocks(5);
      SS_n = 1'b1;
      waitClocks(10);
   endtask

   // Master side: MISO is sampled just before each rising SCLK, 20 clk per bit.
   task automatic shiftBits(input logic [7:0] mosi_byte, input int nbits, output logic [7:0] miso_byte);
      miso_byte = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         MOSI = mosi_byte[i];
         waitClocks(5);
         miso_byte[i] = MISO;
         SCLK = 1'b1;
         waitClocks(10);
         SCLK = 1'b0;
         waitClocks(5);
      end
   endtask

   task automatic applyStimulus(input int idx, input frame_vec_t v);
      logic [7:0]  miso_got;
      logic [15:0] rd;
      cpuWrite(3'd2, 16'h0000);
      if (v.queue_tx) cpuWrite(3'd1, {8'h00, v.tx_byte});
      selectSlave();
      shiftBits(v.mosi_byte, 8, miso_got);
      deselectSlave();
      checkOutput($sformatf("vec%0d miso", idx), {8'h00, miso_got}, {8'h00, v.exp_miso});
      cpuRead(3'd2, rd);
      checkOutput($sformatf("vec%0d status", idx), rd, v.exp_status);
      cpuRead(3'd0, rd);
      checkOutput($sformatf("vec%0d rxdata", idx), rd, {8'h00, v.exp_rx});
      cpuRead(3'd2, rd);
      checkOutput($sformatf("vec%0d status after read", idx), rd, v.exp_status & 16'hFF7F);
   endtask

   initial begin
      logic [15:0] rd;
      logic [7:0]  m1, m2, junk;
      int          rrdy_lat, irq_lat;

      // Every full frame ends with an unprimed reload on the 8th fall, so TUR/E are set.
      vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 16'h03E0};
      vecs[1] = '{1'b0, 8'h00, 8'h5A, 8'h00, 8'h5A, 16'h03E0};
      vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 16'h03E0};
      vecs[3] = '{1'b1, 8'h01, 8'h80, 8'h01, 8'h80, 16'h03E0};
      vecs[4] = '{1'b1, 8'hC3, 8'h7E, 8'hC3, 8'h7E, 16'h03E0};

      reset         = 1'b1;
      spi_select    = 1'b0;
      mem_addr      = 3'd0;
      read_n        = 1'b1;
      write_n       = 1'b1;
      data_from_cpu = 16'h0000;
      SCLK          = 1'b0;
      MOSI          = 1'b0;
      SS_n          = 1'b1;
      waitClocks(3);
      reset = 1'b0;
      waitClocks(5);

      checkOutput("reset data_to_cpu", data_to_cpu, 16'h0000);
      checkOutput("reset MISO", {15'd0, MISO}, 16'h0000);
      checkOutput("reset MISO_en", {15'd0, MISO_en}, 16'h0000);
      checkOutput("reset irq", {15'd0, irq}, 16'h0000);
      checkOutput("reset dataavailable", {15'd0, dataavailable}, 16'h0000);
      checkOutput("reset readyfordata", {15'd0, readyfordata}, 16'h0001);
      cpuRead(3'd2, rd);
      checkOutput("reset status", rd, 16'h0060);

      for (int i = 0; i < 5; i++) applyStimulus(i, vecs[i]);

      // Back-to-back frames: second byte is underrun fill and overruns the unread first.
      cpuWrite(3'd2, 16'h0000);
      cpuWrite(3'd1, 16'h0011);
      selectSlave();
      shiftBits(8'hAA, 8, m1);
      shiftBits(8'h55, 8, m2);
      deselectSlave();
      checkOutput("b2b miso first", {8'h00, m1}, 16'h0011);
      checkOutput("b2b miso second", {8'h00, m2}, 16'h0000);
      cpuRead(3'd2, rd);
      checkOutput("b2b status", rd, 16'h03E8);
      cpuRead(3'd0, rd);
      checkOutput("b2b rxdata", rd, 16'h0055);

      // Double write before select.
      cpuWrite(3'd2, 16'h0000);
      cpuWrite(3'd1, 16'h0077);
      cpuWrite(3'd1, 16'h0099);
      cpuRead(3'd2, rd);
      checkOutput("dbl status", rd, 16'h0110);
      checkOutput("dbl readyfordata", {15'd0, readyfordata}, 16'h0000);
      selectSlave();
      shiftBits(8'h12, 8, m1);
      deselectSlave();
      checkOutput("dbl miso", {8'h00, m1}, 16'h0077);
      cpuRead(3'd0, rd);
      checkOutput("dbl rxdata", rd, 16'h0012);
      cpuWrite(3'd2, 16'h0000);
      cpuRead(3'd2, rd);
      checkOutput("dbl status cleared", rd, 16'h0060);

      // Deselect after 5 bits, then a clean frame.
      cpuWrite(3'd2, 16'h0000);
      selectSlave();
      shiftBits(8'hF0, 5, junk);
      deselectSlave();
      checkOutput("abort dataavailable", {15'd0, dataavailable}, 16'h0000);
      cpuRead(3'd2, rd);
      checkOutput("abort status", rd, 16'h0360);
      cpuWrite(3'd2, 16'h0000);
      selectSlave();
      shiftBits(8'h6B, 8, junk);
      deselectSlave();
      cpuRead(3'd0, rd);
      checkOutput("abort next rxdata", rd, 16'h006B);

      // RRDY / irq latency measured from the 8th SCLK rise.
      cpuWrite(3'd2, 16'h0000);
      cpuWrite(3'd3, 16'h0080);
      cpuRead(3'd3, rd);
`ifdef FINALPROJSOC_SPI_SLAVE_IRQ_EN
      checkOutput("control readback", rd, 16'h0080);
`else
      checkOutput("control readback", rd, 16'h0000);
`endif
      selectSlave();
      shiftBits(8'hC5, 7, junk);
      MOSI = 1'b1;
      waitClocks(5);
      SCLK     = 1'b1;
      rrdy_lat = 0;
      irq_lat  = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (dataavailable && rrdy_lat == 0) rrdy_lat = c;
         if (irq && irq_lat == 0) irq_lat = c;
      end
      SCLK = 1'b0;
      waitClocks(5);
      deselectSlave();
      checkOutput("rrdy latency", rrdy_lat[15:0], 16'd3);
`ifdef FINALPROJSOC_SPI_SLAVE_IRQ_EN
      checkOutput("irq latency", irq_lat[15:0], 16'd4);
`else
      checkOutput("irq latency", irq_lat[15:0], 16'd0);
`endif
      cpuRead(3'd0, rd);
      checkOutput("latency rxdata", rd, 16'h00C5);
      waitClocks(2);
      checkOutput("irq after read", {15'd0, irq}, 16'h0000);

      // Reset mid-frame with SS_n held low: slave must wait for a fresh select.
      selectSlave();
      shiftBits(8'h81, 3, junk);
      reset = 1'b1;
      waitClocks(2);
      reset = 1'b0;
      waitClocks(3);
      checkOutput("midreset MISO_en", {15'd0, MISO_en}, 16'h0000);
      cpuRead(3'd2, rd);
      checkOutput("midreset status", rd, 16'h0060);
      shiftBits(8'hFF, 8, junk);
      checkOutput("midreset ignored frame", {15'd0, dataavailable}, 16'h0000);
      SS_n = 1'b1;
      waitClocks(10);
      selectSlave();
      shiftBits(8'h3A, 8, junk);
      deselectSlave();
      cpuRead(3'd0, rd);
      checkOutput("midreset next rxdata", rd, 16'h003A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
